rr_onehot_grant_gen: RTL and testbench

- Round-robin arbiter that produces a one-hot grant vector from a multi-bit request vector.
- Source side of the "valid implies exactly one bit set" contract that the team's one-hot SVA checkers verify (a |-> $countones(b)==1).
- Sits between N requesters and a single downstream consumer, using a valid/ready handshake.
- Output is registered, and a grant is held stable until it is accepted.

---
 rtl/rr_onehot_grant_gen.sv | 93 +++++++++
 tb/tb_rr_onehot_grant_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rr_onehot_grant_gen.sv
// Round-robin arbiter: turns a request vector into a registered one-hot grant,
// held stable under valid/ready backpressure until the consumer accepts it.
module rr_onehot_grant_gen #(
  parameter int N      = 5,
  parameter int IDX_W  = $clog2(N),
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req,
  input  logic              gnt_ready,
  output logic              gnt_valid,
  output logic [N-1:0]      gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic [HOLD_W-1:0] hold_cnt
);

  logic              accept;
  logic              load;
  logic [IDX_W-1:0]  next_idx;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [N-1:0]      req_rot;
  logic              found;
  logic [IDX_W-1:0]  sel_off;
  logic [IDX_W:0]    sel_sum;

  // ptr_d already reflects an accept on this edge, so a back-to-back selection
  // searches from the slot after the grant being retired rather than the stale ptr.
  always_comb begin
    accept   = gnt_valid_q & gnt_ready;
    load     = ~gnt_valid_q | gnt_ready;
    next_idx = (gnt_idx_q == IDX_W'(N - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
    ptr_d    = accept ? next_idx : ptr_q;
  end

  always_comb begin
    req_rot = N'({req, req} >> ptr_d);
    found   = 1'b0;
    sel_off = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_rot[i]) begin
        found   = 1'b1;
        sel_off = IDX_W'(i);
      end
    end
    sel_sum = {1'b0, ptr_d} + {1'b0, sel_off};
    if (sel_sum >= (IDX_W + 1)'(N)) begin
      sel_sum = sel_sum - (IDX_W + 1)'(N);
    end
  end

  always_comb begin
    gnt_valid_d = gnt_valid_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    hold_cnt_d  = hold_cnt_q;
    if (load) begin
      gnt_valid_d = found;
      gnt_idx_d   = found ? sel_sum[IDX_W-1:0] : '0;
      gnt_d       = found ? (N'(1) << sel_sum[IDX_W-1:0]) : '0;
      hold_cnt_d  = '0;
    end else if (hold_cnt_q != '1) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      hold_cnt_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign hold_cnt  = hold_cnt_q;

endmodule

// File: tb/tb_rr_onehot_grant_gen.sv
// Scoreboard bench for rr_onehot_grant_gen: directed vectors push hand-computed
// expectations, a monitor pops and compares them one cycle after each edge.
module tb_rr_onehot_grant_gen;

  localparam int N      = 5;
  localparam int IDX_W  = 3;
  localparam int HOLD_W = 4;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req;
  logic              gnt_ready;
  logic              gnt_valid;
  logic [N-1:0]      gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic [HOLD_W-1:0] hold_cnt;

  typedef struct {
    string             name;
    logic              v;
    logic [N-1:0]      g;
    logic [IDX_W-1:0]  idx;
    logic [HOLD_W-1:0] h;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  rr_onehot_grant_gen #(.N(N), .IDX_W(IDX_W), .HOLD_W(HOLD_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt_ready (gnt_ready),
    .gnt_valid (gnt_valid),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .hold_cnt  (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic v, input logic [N-1:0] g,
                             input logic [IDX_W-1:0] idx, input logic [HOLD_W-1:0] h);
    compared++;
    if (gnt_valid !== v || gnt !== g || gnt_idx !== idx || hold_cnt !== h) begin
      mismatched++;
      $display("[TB] FAIL %s: got valid=%b gnt=%b idx=%0d hold=%0d, expected valid=%b gnt=%b idx=%0d hold=%0d",
               name, gnt_valid, gnt, gnt_idx, hold_cnt, v, g, idx, h);
    end
  endtask

  // Drive one cycle of inputs and record what the outputs must be after the next edge.
  task automatic applyStimulus(input string name, input logic [N-1:0] r, input logic rdy,
                               input logic v, input logic [N-1:0] g,
                               input logic [IDX_W-1:0] idx, input logic [HOLD_W-1:0] h);
    exp_t e;
    @(negedge clk);
    req       = r;
    gnt_ready = rdy;
    e.name = name; e.v = v; e.g = g; e.idx = idx; e.h = h;
    exp_q.push_back(e);
  endtask

  task automatic drainQueue(input string name);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: scoreboard still holds %0d entries, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput(e.name, e.v, e.g, e.idx, e.h);
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) gnt_valid |-> $countones(gnt) == 1)
    else begin mismatched++; $display("[TB] FAIL sva_onehot: gnt=%b", gnt); end
  a_idle_zero: assert property (@(posedge clk) disable iff (!rst_n) !gnt_valid |-> gnt == '0)
    else begin mismatched++; $display("[TB] FAIL sva_idle_zero: gnt=%b", gnt); end
  a_idx_match: assert property (@(posedge clk) disable iff (!rst_n) gnt_valid |-> gnt[gnt_idx] == 1'b1)
    else begin mismatched++; $display("[TB] FAIL sva_idx_match: gnt=%b idx=%0d", gnt, gnt_idx); end
  a_stable: assert property (@(posedge clk) disable iff (!rst_n) (gnt_valid && !gnt_ready) |=> $stable(gnt))
    else begin mismatched++; $display("[TB] FAIL sva_stable: gnt=%b", gnt); end
  a_req_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(req))
    else begin mismatched++; $display("[TB] FAIL sva_req_known: req=%b", req); end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    gnt_ready = 1'b0;
    #2;
    checkOutput("reset", 1'b0, 5'b00000, 3'd0, 4'd0);
    #20;
    rst_n = 1'b1;

    // Single request; ptr ends at 3 after the accepts.
    applyStimulus("single_0", 5'b00100, 1'b1, 1'b1, 5'b00100, 3'd2, 4'd0);
    applyStimulus("single_1", 5'b00100, 1'b1, 1'b1, 5'b00100, 3'd2, 4'd0);
    applyStimulus("single_2", 5'b00100, 1'b1, 1'b1, 5'b00100, 3'd2, 4'd0);
    applyStimulus("idle_0",   5'b00000, 1'b1, 1'b0, 5'b00000, 3'd0, 4'd0);
    // ptr=3: requests 0 and 1 only, the search wraps past 3 and 4.
    applyStimulus("skip",     5'b00011, 1'b1, 1'b1, 5'b00001, 3'd0, 4'd0);
    applyStimulus("idle_1",   5'b00000, 1'b1, 1'b0, 5'b00000, 3'd0, 4'd0);
    applyStimulus("to_4",     5'b10000, 1'b1, 1'b1, 5'b10000, 3'd4, 4'd0);

    // Full rotation from ptr=0, including the wrap from 4 back to 0.
    applyStimulus("rot_0", 5'b11111, 1'b1, 1'b1, 5'b00001, 3'd0, 4'd0);
    applyStimulus("rot_1", 5'b11111, 1'b1, 1'b1, 5'b00010, 3'd1, 4'd0);
    applyStimulus("rot_2", 5'b11111, 1'b1, 1'b1, 5'b00100, 3'd2, 4'd0);
    applyStimulus("rot_3", 5'b11111, 1'b1, 1'b1, 5'b01000, 3'd3, 4'd0);
    applyStimulus("rot_4", 5'b11111, 1'b1, 1'b1, 5'b10000, 3'd4, 4'd0);
    applyStimulus("rot_5", 5'b11111, 1'b1, 1'b1, 5'b00001, 3'd0, 4'd0);

    // Backpressure: grant 1 held while hold_cnt climbs, even after req drops.
    applyStimulus("bp_load", 5'b01010, 1'b1, 1'b1, 5'b00010, 3'd1, 4'd0);
    applyStimulus("bp_1",    5'b01010, 1'b0, 1'b1, 5'b00010, 3'd1, 4'd1);
    applyStimulus("bp_2",    5'b01010, 1'b0, 1'b1, 5'b00010, 3'd1, 4'd2);
    applyStimulus("bp_3",    5'b01010, 1'b0, 1'b1, 5'b00010, 3'd1, 4'd3);
    applyStimulus("bp_4",    5'b01010, 1'b0, 1'b1, 5'b00010, 3'd1, 4'd4);
    applyStimulus("bp_drop", 5'b00000, 1'b0, 1'b1, 5'b00010, 3'd1, 4'd5);
    applyStimulus("bp_acc",  5'b00000, 1'b1, 1'b0, 5'b00000, 3'd0, 4'd0);

    // Saturation: ptr=2, only requester 0 asks, ready held low for 20 cycles.
    applyStimulus("sat_load", 5'b00001, 1'b0, 1'b1, 5'b00001, 3'd0, 4'd0);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus($sformatf("sat_%0d", i), 5'b00001, 1'b0, 1'b1, 5'b00001, 3'd0,
                    (i > 15) ? 4'd15 : HOLD_W'(i));
    end
    applyStimulus("sat_acc", 5'b01000, 1'b1, 1'b1, 5'b01000, 3'd3, 4'd0);
    applyStimulus("mid_h1",  5'b01000, 1'b0, 1'b1, 5'b01000, 3'd3, 4'd1);
    applyStimulus("mid_h2",  5'b01000, 1'b0, 1'b1, 5'b01000, 3'd3, 4'd2);
    drainQueue("pre_reset");

    // Asynchronous reset between edges drops the held grant immediately.
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, 5'b00000, 3'd0, 4'd0);
    req       = 5'b11111;
    gnt_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("in_reset", 1'b0, 5'b00000, 3'd0, 4'd0);
    #1;
    rst_n = 1'b1;
    applyStimulus("post_rst_0", 5'b11111, 1'b1, 1'b1, 5'b00001, 3'd0, 4'd0);
    applyStimulus("post_rst_1", 5'b11111, 1'b1, 1'b1, 5'b00010, 3'd1, 4'd0);
    applyStimulus("final_idle", 5'b00000, 1'b1, 1'b0, 5'b00000, 3'd0, 4'd0);
    drainQueue("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
